// File: rtl/regfile_pkg.sv
// Shared defaults, types and constants for the multi-port register file.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned NRD_DEFAULT   = 2;
    localparam int unsigned NWR_DEFAULT   = 1;
    localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] reg_data_t;

    // x0 is hardwired to zero: never stored, never reserved.
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A reserve sets a bit, a write clears it; set wins over clear because the
// reserve belongs to a younger instruction than the retiring write.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NWR   = NWR_DEFAULT,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  logic [AW-1:0]      set_addr,
    input  logic [NWR-1:0]     clr_en,
    input  logic [NWR*AW-1:0]  clr_addr,
    output logic [NREGS-1:0]   busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next scoreboard: apply all clears, then the set, then pin x0 low.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned w = 0; w < NWR; w++) begin
            if (clr_en[w]) begin
                busy_d[clr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (set_en && (set_addr != AW'(ZERO_REG))) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // Scoreboard state, synchronously cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard.
// NRD registered read ports with per-port enable (hold on stall), up to two
// write ports where port 1 wins on an address collision.
// Optional macro RF_BYPASS_EN forwards same-cycle write data and post-write
// busy state to the read ports; without it reads see pre-edge state.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = NRD_DEFAULT,
    parameter int unsigned NWR   = NWR_DEFAULT,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    output logic [NREGS-1:0]     busy_vec
);

    logic [XLEN-1:0]     mem_q [NREGS];
    logic [NWR-1:0]      wr_act;
    logic [AW-1:0]       rd_a [NRD];
    logic [XLEN-1:0]     rd_val [NRD];
    logic [NRD-1:0]      rd_bsy;
    logic [NRD*XLEN-1:0] rd_data_q;
    logic [NRD-1:0]      rd_busy_q;

    // Write qualification: x0 writes are dropped at the source.
    always_comb begin
        wr_act = '0;
        for (int unsigned w = 0; w < NWR; w++) begin
            wr_act[w] = wr_en[w] && (wr_addr[w*AW +: AW] != AW'(ZERO_REG));
        end
    end

    // Data array; later write ports are applied last so port 1 wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NWR; w++) begin
                if (wr_act[w]) begin
                    mem_q[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (rsv_en),
        .set_addr (rsv_addr),
        .clr_en   (wr_act),
        .clr_addr (wr_addr),
        .busy_vec (busy_vec)
    );

    // Per-port read value and busy flag, optionally forwarded from this cycle's writes.
    always_comb begin
        for (int unsigned p = 0; p < NRD; p++) begin
            rd_a[p]   = rd_addr[p*AW +: AW];
            rd_val[p] = mem_q[rd_a[p]];
            rd_bsy[p] = busy_vec[rd_a[p]];
`ifdef RF_BYPASS_EN
            for (int unsigned w = 0; w < NWR; w++) begin
                if (wr_act[w] && (wr_addr[w*AW +: AW] == rd_a[p])) begin
                    rd_val[p] = wr_data[w*XLEN +: XLEN];
                    // Write clears busy unless a younger reserve lands on it too.
                    rd_bsy[p] = rsv_en && (rsv_addr == rd_a[p]);
                end
            end
`endif
            if (rd_a[p] == AW'(ZERO_REG)) begin
                rd_val[p] = '0;
                rd_bsy[p] = 1'b0;
            end
        end
    end

    // Read output registers; a deasserted enable holds the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int unsigned p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    rd_data_q[p*XLEN +: XLEN] <= rd_val[p];
                    rd_busy_q[p]              <= rd_bsy[p];
                end
            end
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (NRD = 2, NWR = 2).
module tb_regfile_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NREGS-1:0]    busy_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en  = '0;
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic drv_wr(input int port, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[port]                = 1'b1;
        wr_addr[port*AW +: AW]     = a;
        wr_data[port*XLEN +: XLEN] = d;
    endtask

    task automatic drv_rd(input int port, input logic [AW-1:0] a);
        rd_en[port]            = 1'b1;
        rd_addr[port*AW +: AW] = a;
    endtask

    task automatic drv_rsv(input logic [AW-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
        tick();
        rst = 1'b0;
        checks++;
        if (rd_data !== 64'h0) begin
            errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL reset_busy_vec: got %h want 0", busy_vec);
        end
        // Fill every register, reserve two, and load the read ports.
        for (int i = 1; i < 32; i++) begin
            drv_wr(0, AW'(i), 32'h100 + i);
            tick();
            idle();
        end
        drv_rsv(5'd4); tick(); idle();
        drv_rsv(5'd6); tick(); idle();
        drv_rd(0, 5'd4); drv_rd(1, 5'd6); tick(); idle();
        checks++;
        if (rd_data !== 64'h0000_0106_0000_0104) begin
            errors++; $display("FAIL prefill_rd_data: got %h want 0000010600000104", rd_data);
        end
        checks++;
        if (rd_busy !== 2'b11 || busy_vec !== 32'h0000_0050) begin
            errors++; $display("FAIL prefill_busy: got %b/%h want 11/00000050", rd_busy, busy_vec);
        end
        // Reset mid-operation with all enables active: they must be ignored.
        rst = 1'b1;
        drv_wr(0, 5'd8, 32'hFFFF_FFFF); drv_rsv(5'd10); drv_rd(0, 5'd4);
        tick();
        rst = 1'b0;
        idle();
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++; $display("FAIL midreset_rd: got %h/%b want 0/00", rd_data, rd_busy);
        end
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL midreset_busy_vec: got %h want 0", busy_vec);
        end
        for (int r = 0; r < 32; r += 2) begin
            drv_rd(0, AW'(r)); drv_rd(1, AW'(r + 1)); tick(); idle();
            checks++;
            if (rd_data !== 64'h0) begin
                errors++; $display("FAIL reset_array x%0d/x%0d: got %h want 0", r, r + 1, rd_data);
            end
        end
    endtask

    task automatic test_reg0();
        drv_wr(0, 5'd1, 32'h1111); tick(); idle();
        drv_rd(0, 5'd1); drv_rd(1, 5'd1); tick(); idle();
        drv_wr(0, 5'd0, 32'hDEAD_BEEF); drv_wr(1, 5'd0, 32'hDEAD_BEEF); drv_rsv(5'd0);
        tick(); idle();
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL reg0_busy_vec: got %h want 0", busy_vec);
        end
        drv_rd(0, 5'd0); drv_rd(1, 5'd0); tick(); idle();
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++; $display("FAIL reg0_read: got %h/%b want 0/00", rd_data, rd_busy);
        end
    endtask

    task automatic test_collision();
        drv_wr(0, 5'd5, 32'h11); drv_wr(1, 5'd5, 32'h22); tick(); idle();
        drv_rd(0, 5'd5); drv_rd(1, 5'd5); tick(); idle();
        checks++;
        if (rd_data !== 64'h0000_0022_0000_0022) begin
            errors++; $display("FAIL collision_x5: got %h want 0000002200000022", rd_data);
        end
        drv_wr(0, 5'd12, 32'hAA); drv_wr(1, 5'd13, 32'hBB); tick(); idle();
        drv_rd(0, 5'd12); drv_rd(1, 5'd13); tick(); idle();
        checks++;
        if (rd_data !== 64'h0000_00BB_0000_00AA) begin
            errors++; $display("FAIL dual_write: got %h want 000000bb000000aa", rd_data);
        end
    endtask

    task automatic test_stall();
        drv_wr(0, 5'd3, 32'h33); tick(); idle();
        drv_rd(0, 5'd3); tick(); idle();
        checks++;
        if (rd_data[31:0] !== 32'h33) begin
            errors++; $display("FAIL stall_first: got %h want 33", rd_data[31:0]);
        end
        rd_addr[4:0] = 5'd5;
        drv_wr(0, 5'd3, 32'h44); tick(); idle();
        rd_addr[4:0] = 5'd5;
        checks++;
        if (rd_data[31:0] !== 32'h33) begin
            errors++; $display("FAIL stall_hold1: got %h want 33", rd_data[31:0]);
        end
        tick();
        checks++;
        if (rd_data[31:0] !== 32'h33) begin
            errors++; $display("FAIL stall_hold2: got %h want 33", rd_data[31:0]);
        end
        drv_rd(0, 5'd3); tick(); idle();
        checks++;
        if (rd_data[31:0] !== 32'h44) begin
            errors++; $display("FAIL stall_release: got %h want 44", rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        // Edge N: reserve x7 while reading it; the read sees the old busy state.
        drv_rsv(5'd7); drv_rd(1, 5'd7); tick(); idle();
        checks++;
        if (busy_vec[7] !== 1'b1 || rd_busy[1] !== 1'b0) begin
            errors++; $display("FAIL rsv_edge_n: got busy_vec[7]=%b rd_busy=%b want 1/0",
                               busy_vec[7], rd_busy[1]);
        end
        tick();  // edge N+1
        checks++;
        if (busy_vec[7] !== 1'b1) begin
            errors++; $display("FAIL rsv_n1: got %b want 1", busy_vec[7]);
        end
        drv_rd(1, 5'd7); tick(); idle();  // edge N+2
        checks++;
        if (busy_vec[7] !== 1'b1 || rd_busy[1] !== 1'b1) begin
            errors++; $display("FAIL rsv_n2: got %b/%b want 1/1", busy_vec[7], rd_busy[1]);
        end
        drv_wr(1, 5'd7, 32'h77); tick(); idle();  // edge N+3
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL rsv_clear: got %h want 0", busy_vec);
        end
        drv_rsv(5'd7); drv_wr(0, 5'd7, 32'h78); tick(); idle();
        checks++;
        if (busy_vec !== 32'h0000_0080) begin
            errors++; $display("FAIL rsv_and_write: got %h want 00000080", busy_vec);
        end
        drv_rd(0, 5'd7); tick(); idle();
        checks++;
        if (rd_data[31:0] !== 32'h78 || rd_busy[0] !== 1'b1) begin
            errors++; $display("FAIL rsv_and_write_read: got %h/%b want 78/1",
                               rd_data[31:0], rd_busy[0]);
        end
        drv_wr(0, 5'd7, 32'h0); tick(); idle();
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL rsv_final_clear: got %h want 0", busy_vec);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
        logic        exp_b;
        drv_wr(0, 5'd9, 32'h1); tick(); idle();
        drv_rsv(5'd9); tick(); idle();
        drv_wr(0, 5'd9, 32'h2); drv_rd(0, 5'd9); tick(); idle();
`ifdef RF_BYPASS_EN
        exp_d = 32'h2; exp_b = 1'b0;
`else
        exp_d = 32'h1; exp_b = 1'b1;
`endif
        checks++;
        if (rd_data[31:0] !== exp_d || rd_busy[0] !== exp_b) begin
            errors++; $display("FAIL same_cycle_rw: got %h/%b want %h/%b",
                               rd_data[31:0], rd_busy[0], exp_d, exp_b);
        end
        drv_rd(0, 5'd9); drv_rd(1, 5'd9); tick(); idle();
        checks++;
        if (rd_data !== 64'h0000_0002_0000_0002 || rd_busy !== 2'b00) begin
            errors++; $display("FAIL after_rw: got %h/%b want 0000000200000002/00",
                               rd_data, rd_busy);
        end
        drv_wr(0, 5'd9, 32'h3); drv_wr(1, 5'd9, 32'h4); drv_rsv(5'd9); drv_rd(1, 5'd9);
        tick(); idle();
`ifdef RF_BYPASS_EN
        exp_d = 32'h4; exp_b = 1'b1;
`else
        exp_d = 32'h2; exp_b = 1'b0;
`endif
        checks++;
        if (rd_data[63:32] !== exp_d || rd_busy[1] !== exp_b) begin
            errors++; $display("FAIL same_cycle_dual_rsv: got %h/%b want %h/%b",
                               rd_data[63:32], rd_busy[1], exp_d, exp_b);
        end
        checks++;
        if (busy_vec !== 32'h0000_0200) begin
            errors++; $display("FAIL bypass_busy_vec: got %h want 00000200", busy_vec);
        end
    endtask

    initial begin
        test_reset();
        test_reg0();
        test_collision();
        test_stall();
        test_scoreboard();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
